// File: rtl/melody_pkg.sv
// Shared types and constants for the melody sequencer: FSM state encoding,
// special note codes and song ROM word layout.
package melody_pkg;

   typedef enum logic [2:0] {
      S_IDLE   = 3'd0,
      S_FETCH  = 3'd1,
      S_DECODE = 3'd2,
      S_PLAY   = 3'd3,
      S_GAP    = 3'd4,
      S_FINISH = 3'd5
   } melody_state_e;

   localparam int NOTE_W = 4;
   localparam int DUR_W  = 2;

   localparam logic [NOTE_W-1:0] NOTE_REST = 4'd8;
   localparam logic [NOTE_W-1:0] NOTE_END  = 4'd15;

endpackage

// File: rtl/melody_sequencer_tone_gen.sv
// Square-wave generator: toggles wave every half_period enabled cycles.
// restart clears the phase so every note starts from a low output.
module tone_gen #(
   parameter int DIV_W = 24
) (
   input  logic             clk,
   input  logic             rst_n,
   input  logic             en,
   input  logic             restart,
   input  logic [DIV_W-1:0] half_period,
   output logic             wave
);

   logic [DIV_W-1:0] cnt;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (restart) begin
         cnt  <= '0;
         wave <= 1'b0;
      end else if (en) begin
         if (cnt == half_period - DIV_W'(1)) begin
            cnt  <= '0;
            wave <= ~wave;
         end else begin
            cnt <= cnt + DIV_W'(1);
         end
      end
   end

endmodule

// File: rtl/melody_sequencer.sv
// Song ROM stepper driving the tone generator. Define MELODY_LOOP_EN to
// replay the song continuously until stop instead of playing it once.
module melody_sequencer
   import melody_pkg::*;
#(
   parameter int SONG_LEN      = 32,
   parameter int ADDR_W        = 5,
   parameter int NOTE_DURATION = 12_000_000,
   parameter int GAP_CYCLES    = 1_200_000,
   parameter int DIV_W         = 24,
   parameter int HALF_C        = 45872,
   parameter int HALF_D        = 40872,
   parameter int HALF_E        = 36408,
   parameter int HALF_F        = 34364,
   parameter int HALF_G        = 30612,
   parameter int HALF_A        = 27272,
   parameter int HALF_AHASH    = 25744,
   parameter int HALF_PLUSC    = 22936
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              start,
   input  logic              stop,
   output logic [ADDR_W-1:0] rom_addr,
   input  logic [5:0]        rom_data,
   output logic              busy,
   output logic              done,
   output logic [3:0]        note_idx,
   output logic              speaker_out
);

   localparam logic [2:0] ST_IDLE   = S_IDLE;
   localparam logic [2:0] ST_FETCH  = S_FETCH;
   localparam logic [2:0] ST_DECODE = S_DECODE;
   localparam logic [2:0] ST_PLAY   = S_PLAY;
   localparam logic [2:0] ST_GAP    = S_GAP;
   localparam logic [2:0] ST_FINISH = S_FINISH;

   localparam int GAP_LOAD = (GAP_CYCLES > 0) ? GAP_CYCLES - 1 : 0;

   logic [2:0]        state;
   logic [DIV_W-1:0]  dur_cnt;
   logic [DIV_W-1:0]  half_q;
   logic              tone_q;
   logic              wave;
   logic              tone_en;
   logic              last_step;
   logic [NOTE_W-1:0] code;
   logic [DUR_W-1:0]  dur;

   // Zero half-periods would never match the wrap compare; clamp them to 1.
   function automatic logic [DIV_W-1:0] half_of(input logic [2:0] c);
      int h;
      case (c)
         3'd0:    h = HALF_C;
         3'd1:    h = HALF_D;
         3'd2:    h = HALF_E;
         3'd3:    h = HALF_F;
         3'd4:    h = HALF_G;
         3'd5:    h = HALF_A;
         3'd6:    h = HALF_AHASH;
         default: h = HALF_PLUSC;
      endcase
      if (h < 1) h = 1;
      return DIV_W'(h);
   endfunction

   function automatic logic [DIV_W-1:0] step_load(input logic [DUR_W-1:0] d);
      return DIV_W'((int'(d) + 1) * NOTE_DURATION - 1);
   endfunction

   assign code      = rom_data[5:2];
   assign dur       = rom_data[1:0];
   assign last_step = (rom_addr == ADDR_W'(SONG_LEN - 1));
   assign busy      = (state != ST_IDLE);
   assign done      = (state == ST_FINISH);
   assign tone_en   = (state == ST_PLAY) && tone_q;
   // The wave register may toggle on the PLAY exit edge; gating hides it.
   assign speaker_out = wave & tone_en;

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state    <= ST_IDLE;
         rom_addr <= '0;
         note_idx <= NOTE_REST;
         dur_cnt  <= '0;
         half_q   <= '0;
         tone_q   <= 1'b0;
      end else if (stop && state != ST_IDLE) begin
         state    <= ST_IDLE;
         rom_addr <= '0;
         note_idx <= NOTE_REST;
         dur_cnt  <= '0;
         tone_q   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (start && !stop) begin
                  state    <= ST_FETCH;
                  rom_addr <= '0;
               end
            end
            ST_FETCH: state <= ST_DECODE;
            ST_DECODE: begin
               if (code == NOTE_END) begin
                  state <= ST_FINISH;
               end else begin
                  state    <= ST_PLAY;
                  dur_cnt  <= step_load(dur);
                  half_q   <= half_of(code[2:0]);
                  tone_q   <= (code < NOTE_REST);
                  note_idx <= (code < NOTE_REST) ? code : NOTE_REST;
               end
            end
            ST_PLAY: begin
               if (dur_cnt == '0) begin
                  note_idx <= NOTE_REST;
                  tone_q   <= 1'b0;
                  if (GAP_CYCLES > 0) begin
                     state   <= ST_GAP;
                     dur_cnt <= DIV_W'(GAP_LOAD);
                  end else begin
                     state <= last_step ? ST_FINISH : ST_FETCH;
                     if (!last_step) rom_addr <= rom_addr + ADDR_W'(1);
                  end
               end else begin
                  dur_cnt <= dur_cnt - DIV_W'(1);
               end
            end
            ST_GAP: begin
               if (dur_cnt == '0) begin
                  state <= last_step ? ST_FINISH : ST_FETCH;
                  if (!last_step) rom_addr <= rom_addr + ADDR_W'(1);
               end else begin
                  dur_cnt <= dur_cnt - DIV_W'(1);
               end
            end
            ST_FINISH: begin
               rom_addr <= '0;
`ifdef MELODY_LOOP_EN
               state <= ST_FETCH;
`else
               state <= ST_IDLE;
`endif
            end
            default: state <= ST_IDLE;
         endcase
      end
   end

   tone_gen #(
      .DIV_W(DIV_W)
   ) u_tone (
      .clk        (clk),
      .rst_n      (rst_n),
      .en         (tone_en),
      .restart    (state == ST_DECODE),
      .half_period(half_q),
      .wave       (wave)
   );

endmodule

// File: tb/tb_melody_sequencer.sv
// Scoreboard bench for melody_sequencer: per-cycle expected output records are
// queued when a song is started and compared on each falling clock edge.
module tb_melody_sequencer;

   localparam int SONG_LEN = 4;
   localparam int ND       = 12;
   localparam int GAP      = 2;

   logic       clk = 1'b0;
   logic       rst_n;
   logic       start;
   logic       stop;
   logic [4:0] rom_addr;
   logic [5:0] rom_data = 6'd0;
   logic       busy;
   logic       done;
   logic [3:0] note_idx;
   logic       speaker_out;

   logic [5:0]  rom [0:31];
   int          half_tab [0:7] = '{9, 8, 7, 6, 5, 4, 3, 2};
   logic [11:0] exp_q [$];
   logic [11:0] trace [$];
   logic [11:0] e;
   string       cur_tag = "init";
   int          pop_idx = 0;
   int          n_vec = 0;
   int          n_err = 0;

   always #5 clk = ~clk;

   melody_sequencer #(
      .SONG_LEN(SONG_LEN), .ADDR_W(5), .NOTE_DURATION(ND), .GAP_CYCLES(GAP),
      .DIV_W(24), .HALF_C(9), .HALF_D(8), .HALF_E(7), .HALF_F(6), .HALF_G(5),
      .HALF_A(4), .HALF_AHASH(3), .HALF_PLUSC(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .start(start), .stop(stop), .rom_addr(rom_addr),
      .rom_data(rom_data), .busy(busy), .done(done), .note_idx(note_idx),
      .speaker_out(speaker_out)
   );

   // Synchronous song ROM: data follows the address by one clock.
   always @(posedge clk) rom_data <= rom[rom_addr];

   task automatic chk_val(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      n_vec++;
      if (obs !== expv) begin
         n_err++;
         $display("FAIL %s: got %h expected %h (addr,busy,done,note,spk)", tag, obs, expv);
      end
   endtask

   function automatic logic [11:0] rec(input int a, input bit b, input bit d, input int n, input bit s);
      return {5'(a), b, d, 4'(n), s};
   endfunction

   always @(negedge clk) begin
      if (exp_q.size() > 0) begin
         e = exp_q.pop_front();
         chk_val($sformatf("%s[%0d]", cur_tag, pop_idx),
                 32'({rom_addr, busy, done, note_idx, speaker_out}), 32'(e));
         pop_idx++;
      end
   end

   // Expected timeline of the whole song, written step by step from the ROM image.
   task automatic build_trace();
      int passes;
      int addr;
      int n;
      int len;
      bit fin;
      bit tone;
`ifdef MELODY_LOOP_EN
      passes = 2;
`else
      passes = 1;
`endif
      trace.delete();
      trace.push_back(rec(0, 0, 0, 8, 0));
      for (int p = 0; p < passes; p++) begin
         addr = 0;
         fin  = 0;
         while (!fin) begin
            n = int'(rom[addr][5:2]);
            trace.push_back(rec(addr, 1, 0, 8, 0));
            trace.push_back(rec(addr, 1, 0, 8, 0));
            if (n == 15) begin
               trace.push_back(rec(addr, 1, 1, 8, 0));
               fin = 1;
            end else begin
               len  = (int'(rom[addr][1:0]) + 1) * ND;
               tone = (n < 8);
               for (int j = 0; j < len; j++)
                  trace.push_back(rec(addr, 1, 0, tone ? n : 8,
                                      tone ? bit'((j / half_tab[n[2:0]]) % 2) : 1'b0));
               for (int g = 0; g < GAP; g++) trace.push_back(rec(addr, 1, 0, 8, 0));
               if (addr == SONG_LEN - 1) begin
                  trace.push_back(rec(addr, 1, 1, 8, 0));
                  fin = 1;
               end else begin
                  addr++;
               end
            end
         end
      end
`ifndef MELODY_LOOP_EN
      for (int k = 0; k < 3; k++) trace.push_back(rec(0, 0, 0, 8, 0));
`endif
   endtask

   task automatic drain(input int budget);
      for (int i = 0; i < budget && exp_q.size() > 0; i++) @(posedge clk);
      if (exp_q.size() > 0) begin
         chk_val({cur_tag, "_timeout"}, 32'(exp_q.size()), 32'd0);
         exp_q.delete();
      end
   endtask

   // kind: 0 = play through, 1 = stop takes effect at record cut, 2 = reset at record cut.
   task automatic run(input int cut_in, input int kind_in, input int pulse_at, input string tag);
      int total;
      int cut;
      int kind;
      cut  = cut_in;
      kind = kind_in;
      build_trace();
`ifdef MELODY_LOOP_EN
      if (cut == 0) begin
         cut  = trace.size();
         kind = 1;
      end
`endif
      @(posedge clk); #1;
      cur_tag = tag;
      total = (cut == 0) ? trace.size() : cut + 3;
      for (int i = 0; i < total; i++)
         exp_q.push_back((cut == 0 || i < cut) ? trace[i] : rec(0, 0, 0, 8, 0));
      for (int c = 0; c < total; c++) begin
         start = (c == 0) || (c + 1 == pulse_at);
         stop  = (kind == 1) && (c + 1 == cut);
         rst_n = !((kind == 2) && (c + 1 == cut));
         @(posedge clk); #1;
      end
      start = 1'b0;
      stop  = 1'b0;
      rst_n = 1'b1;
      drain(20);
   endtask

   task automatic load_song1();
      for (int i = 0; i < 32; i++) rom[i] = 6'h3C;
      rom[0] = {4'd0, 2'd0};
      rom[1] = {4'd1, 2'd1};
      rom[2] = {4'd8, 2'd0};
      rom[3] = {4'd15, 2'd0};
   endtask

   task automatic load_song2();
      for (int i = 0; i < 32; i++) rom[i] = 6'h3C;
      rom[0] = {4'd2, 2'd0};
      rom[1] = {4'd4, 2'd0};
      rom[2] = {4'd5, 2'd1};
      rom[3] = {4'd7, 2'd0};
   endtask

   initial begin
      rst_n = 1'b0;
      start = 1'b0;
      stop  = 1'b0;
      load_song1();

      @(posedge clk); #1;
      cur_tag = "reset";
      exp_q.push_back(rec(0, 0, 0, 8, 0));
      exp_q.push_back(rec(0, 0, 0, 8, 0));
      @(posedge clk); #1;
      @(posedge clk); #1;
      rst_n = 1'b1;
      drain(10);

      run(0, 0, 0, "song1");

      load_song2();
      run(0, 0, 10, "song2_restart");

      load_song1();
      run(24, 1, 0, "stop_mid");

      @(posedge clk); #1;
      cur_tag = "start_stop";
      for (int i = 0; i < 4; i++) exp_q.push_back(rec(0, 0, 0, 8, 0));
      start = 1'b1;
      stop  = 1'b1;
      @(posedge clk); #1;
      start = 1'b0;
      stop  = 1'b0;
      drain(10);

      run(30, 2, 0, "rst_mid");
      run(0, 0, 0, "replay");

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
